wb_write_buffer: RTL and testbench

//   Writer side of the register file's write-back port.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_ptr_ctrl.sv | 57 +++++
 rtl/wb_write_buffer.sv | 105 ++++++++++
 tb/tb_wb_write_buffer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back buffer.
//   DATA_W    : write-back value width
//   ADDR_W    : register index width
//   NUM_REGS  : number of architectural registers (width of the pending mask)
//   wb_entry_t: one buffered result {dest, value}
//   reg_mask_t: one bit per architectural register
package wb_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] value;
  } wb_entry_t;

  typedef logic [NUM_REGS-1:0] reg_mask_t;

endpackage

// File: rtl/wb_ptr_ctrl.sv
// Pointer and occupancy control for the write-back FIFO.
// Qualifies pushes (valid, writing, not full) and pops (non-empty, not held),
// and keeps head/tail pointers and the occupancy count.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_wb_en   : offer from MEM/WB and whether it writes a register
//   wb_hold              : suppresses the pop this cycle
//   in_ready             : !full
//   push, pop            : qualified FIFO operations for this cycle
//   empty                : count == 0
//   head, tail           : read / write pointers (wrap modulo DEPTH)
//   count                : occupancy 0..DEPTH
module wb_ptr_ctrl
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_wb_en,
  input  logic                     wb_hold,
  output logic                     in_ready,
  output logic                     push,
  output logic                     pop,
  output logic                     empty,
  output logic [$clog2(DEPTH)-1:0] head,
  output logic [$clog2(DEPTH)-1:0] tail,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic full;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  // A full buffer refuses the offer even if the head drains this same cycle.
  assign push     = in_valid & in_ready & in_wb_en;
  assign pop      = !empty & !wb_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_write_buffer.sv
// Write-back buffer: queues completed MEM/WB results in an in-order FIFO and
// drives one register-file write per cycle from the head entry. Also publishes
// a mask of registers that still have a buffered write in flight.
// Optional feature macro: WB_BUF_FWD_EN adds a forwarding lookup
// (fwd_src -> fwd_hit/fwd_value, youngest matching entry wins).
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready            : offer handshake from MEM/WB
//   in_wb_en, in_dest, in_value  : result (in_wb_en=0 is a bubble, discarded)
//   wb_hold                      : suppress the register-file write this cycle
//   wb_en, wb_dest, wb_value     : register-file write port (sampled on negedge)
//   pending_mask                 : bit r set while any entry targets register r
//   fwd_src, fwd_hit, fwd_value  : forwarding lookup (WB_BUF_FWD_EN only)
//   count                        : occupancy
module wb_write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_wb_en,
  input  logic [ADDR_W-1:0]      in_dest,
  input  logic [DATA_W-1:0]      in_value,
  input  logic                   wb_hold,
  output logic                   wb_en,
  output logic [ADDR_W-1:0]      wb_dest,
  output logic [DATA_W-1:0]      wb_value,
  output reg_mask_t              pending_mask,
`ifdef WB_BUF_FWD_EN
  input  logic [ADDR_W-1:0]      fwd_src,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_value,
`endif
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] rd_idx;
  logic             push;
  logic             pop;
  logic             empty;
  wb_entry_t        mem [DEPTH];

  wb_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_wb_en (in_wb_en),
    .wb_hold  (wb_hold),
    .in_ready (in_ready),
    .push     (push),
    .pop      (pop),
    .empty    (empty),
    .head     (head),
    .tail     (tail),
    .count    (count)
  );

  // Storage is cleared on reset so the write port reads 0 right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[tail] <= '{dest: in_dest, value: in_value};
    end
  end

  // When empty, point at the slot just drained so dest/value hold the last
  // write. A push while empty lands at head, never at head-1, so this slot
  // stays stable until the FIFO is non-empty again.
  assign rd_idx   = empty ? head - PTR_W'(1) : head;
  assign wb_en    = pop;
  assign wb_dest  = mem[rd_idx].dest;
  assign wb_value = mem[rd_idx].value;

  // Walk live entries from head; offset k is live while k < count.
  always_comb begin
    pending_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count) pending_mask[mem[head + PTR_W'(k)].dest] = 1'b1;
    end
  end

`ifdef WB_BUF_FWD_EN
  // Oldest-to-youngest scan: a later match overwrites an earlier one.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_value = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CNT_W'(k) < count && mem[head + PTR_W'(k)].dest == fwd_src) begin
        fwd_hit   = 1'b1;
        fwd_value = mem[head + PTR_W'(k)].value;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_write_buffer.sv
module tb_wb_write_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wb_en;
  logic [3:0]  in_dest;
  logic [31:0] in_value;
  logic        wb_hold;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [15:0] pending_mask;
  logic [2:0]  count;
`ifdef WB_BUF_FWD_EN
  logic [3:0]  fwd_src;
  logic        fwd_hit;
  logic [31:0] fwd_value;
`endif

  wb_write_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wb_en     (in_wb_en),
    .in_dest      (in_dest),
    .in_value     (in_value),
    .wb_hold      (wb_hold),
    .wb_en        (wb_en),
    .wb_dest      (wb_dest),
    .wb_value     (wb_value),
    .pending_mask (pending_mask),
`ifdef WB_BUF_FWD_EN
    .fwd_src      (fwd_src),
    .fwd_hit      (fwd_hit),
    .fwd_value    (fwd_value),
`endif
    .count        (count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic e, logic h, logic [3:0] d, logic [31:0] val);
    in_valid = v;
    in_wb_en = e;
    wb_hold  = h;
    in_dest  = d;
    in_value = val;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue of buffered writes plus the last drained one.
  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] value;
  } ent_t;

  ent_t q[$];
  ent_t last_e;

  task automatic model_reset();
    q.delete();
    last_e = '0;
  endtask

  function automatic logic [15:0] model_mask();
    logic [15:0] m = '0;
    foreach (q[i]) m[q[i].dest] = 1'b1;
    return m;
  endfunction

  task automatic check_model(string tag);
    ent_t shown = (q.size() != 0) ? q[0] : last_e;
    chk({tag, "_ready"}, 64'(in_ready), 64'(q.size() < DEPTH));
    chk({tag, "_wb_en"}, 64'(wb_en), 64'(q.size() != 0 && !wb_hold));
    chk({tag, "_dest"},  64'(wb_dest), 64'(shown.dest));
    chk({tag, "_value"}, 64'(wb_value), 64'(shown.value));
    chk({tag, "_mask"},  64'(pending_mask), 64'(model_mask()));
    chk({tag, "_count"}, 64'(count), 64'(q.size()));
`ifdef WB_BUF_FWD_EN
    begin
      logic        hit = 1'b0;
      logic [31:0] val = '0;
      foreach (q[i]) if (q[i].dest == fwd_src) begin hit = 1'b1; val = q[i].value; end
      chk({tag, "_fwd_hit"}, 64'(fwd_hit), 64'(hit));
      chk({tag, "_fwd_val"}, 64'(fwd_value), 64'(val));
    end
`endif
  endtask

  // Apply the effect of the coming clock edge to the model.
  task automatic model_edge();
    bit rdy = (q.size() < DEPTH);
    bit pp  = (q.size() != 0) && !wb_hold;
    if (pp) last_e = q.pop_front();
    if (in_valid && rdy && in_wb_en) q.push_back('{dest: in_dest, value: in_value});
  endtask

  typedef struct {
    logic        v, e, h;
    logic [3:0]  d;
    logic [31:0] val;
    logic        x_en;
    logic [3:0]  x_dest;
    logic [31:0] x_val;
    logic [15:0] x_mask;
    logic [2:0]  x_cnt;
    logic        x_rdy;
  } vec_t;

  localparam int NV = 19;
  vec_t vt [NV];

  initial begin
    // Single push, bubble, same dest twice, hold-until-full then drain.
    vt[0]  = '{1'b1,1'b1,1'b0,4'd5,32'hDEADBEEF, 1'b0,4'd0,32'h0,       16'h0000,3'd0,1'b1};
    vt[1]  = '{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b1,4'd5,32'hDEADBEEF,16'h0020,3'd1,1'b1};
    vt[2]  = '{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd5,32'hDEADBEEF,16'h0000,3'd0,1'b1};
    vt[3]  = '{1'b1,1'b0,1'b0,4'd9,32'h1234,     1'b0,4'd5,32'hDEADBEEF,16'h0000,3'd0,1'b1};
    vt[4]  = '{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd5,32'hDEADBEEF,16'h0000,3'd0,1'b1};
    vt[5]  = '{1'b1,1'b1,1'b0,4'd3,32'd1,        1'b0,4'd5,32'hDEADBEEF,16'h0000,3'd0,1'b1};
    vt[6]  = '{1'b1,1'b1,1'b0,4'd3,32'd2,        1'b1,4'd3,32'd1,       16'h0008,3'd1,1'b1};
    vt[7]  = '{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b1,4'd3,32'd2,       16'h0008,3'd1,1'b1};
    vt[8]  = '{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd3,32'd2,       16'h0000,3'd0,1'b1};
    vt[9]  = '{1'b1,1'b1,1'b1,4'd1,32'h11,       1'b0,4'd3,32'd2,       16'h0000,3'd0,1'b1};
    vt[10] = '{1'b1,1'b1,1'b1,4'd2,32'h22,       1'b0,4'd1,32'h11,      16'h0002,3'd1,1'b1};
    vt[11] = '{1'b1,1'b1,1'b1,4'd4,32'h33,       1'b0,4'd1,32'h11,      16'h0006,3'd2,1'b1};
    vt[12] = '{1'b1,1'b1,1'b1,4'd8,32'h44,       1'b0,4'd1,32'h11,      16'h0016,3'd3,1'b1};
    vt[13] = '{1'b1,1'b1,1'b1,4'd6,32'h55,       1'b0,4'd1,32'h11,      16'h0116,3'd4,1'b0};
    vt[14] = '{1'b1,1'b1,1'b0,4'd6,32'h55,       1'b1,4'd1,32'h11,      16'h0116,3'd4,1'b0};
    vt[15] = '{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b1,4'd2,32'h22,      16'h0114,3'd3,1'b1};
    vt[16] = '{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b1,4'd4,32'h33,      16'h0110,3'd2,1'b1};
    vt[17] = '{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b1,4'd8,32'h44,      16'h0100,3'd1,1'b1};
    vt[18] = '{1'b0,1'b0,1'b0,4'd0,32'h0,        1'b0,4'd8,32'h44,      16'h0000,3'd0,1'b1};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
`ifdef WB_BUF_FWD_EN
    fwd_src = 4'd0;
`endif
    model_reset();
    tick();
    tick();
    chk("reset_wb_en", 64'(wb_en), 64'(0));
    chk("reset_count", 64'(count), 64'(0));
    chk("reset_mask",  64'(pending_mask), 64'(0));
    chk("reset_ready", 64'(in_ready), 64'(1));
    chk("reset_dest",  64'(wb_dest), 64'(0));
    chk("reset_value", 64'(wb_value), 64'(0));
    rst = 1'b0;

    // Table-driven directed vectors.
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].v, vt[i].e, vt[i].h, vt[i].d, vt[i].val);
      #1;
      chk($sformatf("row%0d_wb_en", i), 64'(wb_en), 64'(vt[i].x_en));
      chk($sformatf("row%0d_dest", i),  64'(wb_dest), 64'(vt[i].x_dest));
      chk($sformatf("row%0d_value", i), 64'(wb_value), 64'(vt[i].x_val));
      chk($sformatf("row%0d_mask", i),  64'(pending_mask), 64'(vt[i].x_mask));
      chk($sformatf("row%0d_count", i), 64'(count), 64'(vt[i].x_cnt));
      chk($sformatf("row%0d_ready", i), 64'(in_ready), 64'(vt[i].x_rdy));
      tick();
    end

    // Reset asserted between clock edges while the buffer is draining.
    drive(1'b1, 1'b1, 1'b1, 4'd10, 32'hA0); tick();
    drive(1'b1, 1'b1, 1'b1, 4'd11, 32'hB0); tick();
    drive(1'b1, 1'b1, 1'b1, 4'd12, 32'hC0); tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    #1;
    chk("drain_count3", 64'(count), 64'(3));
    chk("drain_dest_a", 64'(wb_dest), 64'(10));
    tick();
    chk("drain_count2", 64'(count), 64'(2));
    chk("drain_wb_en",  64'(wb_en), 64'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_wb_en", 64'(wb_en), 64'(0));
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_mask",  64'(pending_mask), 64'(0));
    chk("midrst_ready", 64'(in_ready), 64'(1));
    chk("midrst_dest",  64'(wb_dest), 64'(0));
    chk("midrst_value", 64'(wb_value), 64'(0));
    #1;
    rst = 1'b0;
    tick();
    chk("postrst_wb_en", 64'(wb_en), 64'(0));
    chk("postrst_count", 64'(count), 64'(0));
    model_reset();

`ifdef WB_BUF_FWD_EN
    // Forwarding picks the youngest of two writes to the same register.
    drive(1'b1, 1'b1, 1'b1, 4'd7, 32'd10); tick();
    drive(1'b1, 1'b1, 1'b1, 4'd7, 32'd20); tick();
    drive(1'b0, 1'b0, 1'b1, 4'd0, 32'd0);
    fwd_src = 4'd7;
    #1;
    chk("fwd7_hit", 64'(fwd_hit), 64'(1));
    chk("fwd7_val", 64'(fwd_value), 64'(20));
    fwd_src = 4'd8;
    #1;
    chk("fwd8_hit", 64'(fwd_hit), 64'(0));
    chk("fwd8_val", 64'(fwd_value), 64'(0));
    rst = 1'b1;
    #1;
    rst = 1'b0;
    model_reset();
    tick();
`endif

    // Randomised traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(99) < 60) ? 1'b1 : 1'b0,
            ($urandom_range(99) < 80) ? 1'b1 : 1'b0,
            ($urandom_range(99) < 35) ? 1'b1 : 1'b0,
            4'($urandom_range(15)),
            32'($urandom));
`ifdef WB_BUF_FWD_EN
      fwd_src = 4'($urandom_range(15));
`endif
      #1;
      check_model("rnd");
      model_edge();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
